req_capture_enc4: RTL and testbench

Captures activity on four raw request lines and feeds it to the 4-to-2 encoding stage. Each line is synchronized and, optionally, debounced. Rising edges are detected and priority-encoded into a 2-bit code, which is queued in a small FIFO and handed downstream over a valid/ready handshake. The block sits between asynchronous request sources (keys, status strobes) and the consumer of encoded indices, and turns level inputs into discrete, lossless-until-full events.

---
 rtl/req_capture_enc4.sv | 178 +++++++++++++++++
 tb/tb_req_capture_enc4.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_capture_enc4.sv
// Request capture: 2-flop sync, optional debounce (define DEBOUNCE_EN), rising-edge
// detect, 4-to-2 priority encode and a small FIFO with a valid/ready output.
module req_capture_enc4 #(
  parameter int DEPTH     = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               D,
  output logic [1:0]               Y,
  output logic                     multi,
  output logic                     valid,
  input  logic                     ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  typedef struct packed {
    logic       multi;
    logic [1:0] code;
  } entry_t;

  logic [3:0] s1_q;
  logic [3:0] ds_q;
  logic [3:0] dq;
  logic [3:0] dqPrev_q;
  logic [3:0] rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      ds_q <= '0;
    end else begin
      s1_q <= D;
      ds_q <= s1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CntLast = CW'(DB_CYCLES - 1);

  logic [3:0]    dq_q;
  logic [3:0]    dq_d;
  logic [CW-1:0] dbCnt_q [4];
  logic [CW-1:0] dbCnt_d [4];

  // A bit flips only after disagreeing with the synchronized input for DB_CYCLES edges.
  always_comb begin
    dq_d = dq_q;
    for (int i = 0; i < 4; i++) begin
      dbCnt_d[i] = dbCnt_q[i];
      if (ds_q[i] == dq_q[i]) begin
        dbCnt_d[i] = '0;
      end else if (dbCnt_q[i] == CntLast) begin
        dq_d[i]    = ds_q[i];
        dbCnt_d[i] = '0;
      end else begin
        dbCnt_d[i] = dbCnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_q <= '0;
      for (int i = 0; i < 4; i++) begin
        dbCnt_q[i] <= '0;
      end
    end else begin
      dq_q <= dq_d;
      for (int i = 0; i < 4; i++) begin
        dbCnt_q[i] <= dbCnt_d[i];
      end
    end
  end

  assign dq = dq_q;
`else
  assign dq = ds_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dqPrev_q <= '0;
    end else begin
      dqPrev_q <= dq;
    end
  end

  assign rise = dq & ~dqPrev_q;

  entry_t     newEntry;
  logic [2:0] riseOnes;

  always_comb begin
    newEntry = '0;
    riseOnes = {2'b00, rise[0]} + {2'b00, rise[1]} + {2'b00, rise[2]} + {2'b00, rise[3]};
    if (rise[3]) begin
      newEntry.code = 2'd3;
    end else if (rise[2]) begin
      newEntry.code = 2'd2;
    end else if (rise[1]) begin
      newEntry.code = 2'd1;
    end else begin
      newEntry.code = 2'd0;
    end
    newEntry.multi = (riseOnes > 3'd1);
  end

  entry_t      mem_q [DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] wptr_d;
  logic [AW:0] rptr_q;
  logic [AW:0] rptr_d;
  logic        overflow_q;
  logic        overflow_d;
  logic        push;
  logic        pop;
  logic        full;
  logic        doPush;
  logic        drop;
  entry_t      head;

  assign count  = wptr_q - rptr_q;
  assign valid  = (count != '0);
  assign full   = (count == FullCnt);
  assign push   = (rise != 4'b0000);
  assign pop    = valid && ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign doPush = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    if (doPush) begin
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      if (doPush) begin
        mem_q[wptr_q[AW-1:0]] <= newEntry;
      end
    end
  end

  assign head     = valid ? mem_q[rptr_q[AW-1:0]] : '0;
  assign Y        = head.code;
  assign multi    = head.multi;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_req_capture_enc4.sv
// Scoreboard bench for req_capture_enc4; expected entries are queued as stimulus is
// driven and compared as the DUT presents them at the FIFO head.
module tb_req_capture_enc4;

`ifdef DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = 12;

  logic       clk;
  logic       rst_n;
  logic [3:0] D;
  logic [1:0] Y;
  logic       multi;
  logic       valid;
  logic       ready;
  logic [2:0] count;
  logic       overflow;
  logic       ovf_clr;

  int         testsRun;
  int         failCount;
  logic [2:0] expQ [$];

  req_capture_enc4 #(.DEPTH(4), .DB_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D        (D),
    .Y        (Y),
    .multi    (multi),
    .valid    (valid),
    .ready    (ready),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pops the scoreboard against the FIFO head with ready held high.
  task automatic drainQueue(input string name, input int budget, output int used);
    logic [2:0] exp;
    used  = 0;
    ready = 1'b1;
    while (expQ.size() > 0 && used < budget) begin
      if (valid) begin
        exp = expQ.pop_front();
        testsRun++;
        if ({multi, Y} !== exp) begin
          failCount++;
          $display("[TB] FAIL %s head: got {multi,Y}=%b expected %b", name, {multi, Y}, exp);
        end
      end
      @(negedge clk);
      used++;
    end
    ready = 1'b0;
    testsRun++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL %s drain timeout: %0d entries left, expected 0", name, expQ.size());
      expQ.delete();
    end
    testsRun++;
    if (valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL %s extra entries: valid=%b expected 0", name, valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; D = '0; ready = 1'b0; ovf_clr = 1'b0;
    waitNeg(2);
    testsRun++;
    if ({Y, multi, valid, count, overflow} !== 8'b0) begin
      failCount++;
      $display("[TB] FAIL reset outputs: got %b expected 00000000", {Y, multi, valid, count, overflow});
    end
    rst_n = 1'b1;
    waitNeg(5);
    testsRun++;
    if (valid !== 1'b0 || count !== 3'd0) begin
      failCount++;
      $display("[TB] FAIL idle after reset: valid=%b count=%0d expected 0/0", valid, count);
    end
  endtask

  task automatic test_single();
    logic [2:0] exp;
    D = 4'b0001;
    expQ.push_back(3'b000);
    waitNeg(LAT - 1);
    testsRun++;
    if (valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL single early: valid=%b expected 0 before edge %0d", valid, LAT);
    end
    waitNeg(1);
    testsRun++;
    if (valid !== 1'b1 || count !== 3'd1) begin
      failCount++;
      $display("[TB] FAIL single latency: valid=%b count=%0d expected 1/1", valid, count);
    end
    exp = expQ.pop_front();
    testsRun++;
    if ({multi, Y} !== exp) begin
      failCount++;
      $display("[TB] FAIL single head: got %b expected %b", {multi, Y}, exp);
    end
    ready = 1'b1;
    waitNeg(1);
    ready = 1'b0;
    testsRun++;
    if (valid !== 1'b0 || count !== 3'd0) begin
      failCount++;
      $display("[TB] FAIL single pop: valid=%b count=%0d expected 0/0", valid, count);
    end
    waitNeg(5);
    testsRun++;
    if (count !== 3'd0) begin
      failCount++;
      $display("[TB] FAIL single held level: count=%0d expected 0", count);
    end
    D = 4'b0000;
    waitNeg(HOLD);
  endtask

  task automatic test_sequence();
    int used;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      D = 4'b0001 << i;
      expQ.push_back({1'b0, 2'(i)});
      waitNeg(HOLD);
    end
    D = 4'b0000;
    waitNeg(HOLD);
    testsRun++;
    if (count !== 3'd4) begin
      failCount++;
      $display("[TB] FAIL sequence count: got %0d expected 4", count);
    end
    drainQueue("sequence", 20, used);
    testsRun++;
    if (used !== 4) begin
      failCount++;
      $display("[TB] FAIL sequence throughput: drained in %0d cycles expected 4", used);
    end
  endtask

  task automatic test_multi();
    int used;
    D = 4'b1010;
    expQ.push_back(3'b111);
    waitNeg(20);
    testsRun++;
    if (count !== 3'd1) begin
      failCount++;
      $display("[TB] FAIL multi held level: count=%0d expected 1", count);
    end
    drainQueue("multi", 10, used);
    D = 4'b0000;
    waitNeg(HOLD);
  endtask

  task automatic test_overflow();
    int used;
    logic [2:0] exp;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      D = 4'b0001 << (i % 4);
      if (i < 4) expQ.push_back({1'b0, 2'(i % 4)});
      waitNeg(HOLD);
      D = 4'b0000;
      waitNeg(HOLD);
    end
    testsRun++;
    if (count !== 3'd4 || overflow !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL overflow set: count=%0d overflow=%b expected 4/1", count, overflow);
    end
    ovf_clr = 1'b1;
    waitNeg(1);
    ovf_clr = 1'b0;
    testsRun++;
    if (overflow !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL overflow clear: overflow=%b expected 0", overflow);
    end
    D = 4'b0010;
    waitNeg(LAT - 1);
    testsRun++;
    if (count !== 3'd4) begin
      failCount++;
      $display("[TB] FAIL full before push: count=%0d expected 4", count);
    end
    exp = expQ.pop_front();
    testsRun++;
    if ({multi, Y} !== exp) begin
      failCount++;
      $display("[TB] FAIL full pop head: got %b expected %b", {multi, Y}, exp);
    end
    expQ.push_back(3'b001);
    ready = 1'b1;
    waitNeg(1);
    ready = 1'b0;
    testsRun++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL full push+pop: count=%0d overflow=%b expected 4/0", count, overflow);
    end
    D = 4'b0000;
    drainQueue("overflow", 20, used);
    waitNeg(HOLD);
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_debounce();
    int used;
    D = 4'b0100;
    waitNeg(3);
    D = 4'b0000;
    waitNeg(15);
    testsRun++;
    if (valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL debounce short pulse: valid=%b expected 0", valid);
    end
    D = 4'b0100;
    expQ.push_back(3'b010);
    waitNeg(6);
    D = 4'b0000;
    testsRun++;
    if (valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL debounce early: valid=%b expected 0", valid);
    end
    waitNeg(1);
    testsRun++;
    if (valid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL debounce latency: valid=%b expected 1", valid);
    end
    drainQueue("debounce", 10, used);
    waitNeg(HOLD);
  endtask
`endif

  task automatic test_reset_mid();
    int used;
    ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      D = 4'b0001 << i;
      expQ.push_back({1'b0, 2'(i)});
      waitNeg(HOLD);
    end
    D = 4'b0000;
    waitNeg(HOLD);
    testsRun++;
    if (count !== 3'd3 || Y !== 2'd1) begin
      failCount++;
      $display("[TB] FAIL pre-reset state: count=%0d Y=%0d expected 3/1", count, Y);
    end
    D = 4'b0001;
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({valid, count, Y, overflow} !== 7'b0) begin
      failCount++;
      $display("[TB] FAIL async reset: {valid,count,Y,ovf}=%b expected 0000000", {valid, count, Y, overflow});
    end
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    expQ.push_back(3'b000);
    waitNeg(LAT);
    testsRun++;
    if (valid !== 1'b1 || count !== 3'd1) begin
      failCount++;
      $display("[TB] FAIL event after reset: valid=%b count=%0d expected 1/1", valid, count);
    end
    drainQueue("reset_mid", 10, used);
    D = 4'b0000;
    waitNeg(HOLD);
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst_n     = 1'b0;
    D         = '0;
    ready     = 1'b0;
    ovf_clr   = 1'b0;
    test_reset();
    test_single();
    test_sequence();
    test_multi();
    test_overflow();
`ifdef DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
